// File: rtl/bus_gate_arbiter.sv
// Round-robin bus gate arbiter: drives a registered one-hot Gate for four bus
// sources with bounded tenure, lock override and gap-free owner handover.
module bus_gate_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = $clog2(MAX_HOLD + 1)
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] Req,
  input  logic       Lock,
  output logic [3:0] Gate,
  output logic       Grant_valid,
  output logic [1:0] Grant_id,
  output logic       Timeout
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state, state_n;
  logic [1:0]         rr_ptr, ptr_n;
  logic [CNT_W-1:0]   hold_cnt, cnt_n;
  logic [3:0]         gate_n;
  logic               valid_n;
  logic [1:0]         id_n;
  logic               to_n;
  logic               grant;
  logic [3:0]         cand;
  logic [2:0]         pick_res;
  logic               owner_req;
  logic [3:0]         others;
  logic               at_limit;

  // Returns {found, index} of the first set bit of r scanning upward from p.
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] idx;
    res = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = p + 2'(i);
      if (!res[2] && r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign owner_req = Req[Grant_id];
  assign others    = Req & ~Gate;
  assign at_limit  = (hold_cnt == CNT_W'(MAX_HOLD));
  assign pick_res  = pick(cand, rr_ptr);

  always_comb begin
    state_n = state;
    gate_n  = Gate;
    valid_n = Grant_valid;
    id_n    = Grant_id;
    to_n    = 1'b0;
    ptr_n   = rr_ptr;
    cnt_n   = hold_cnt;
    grant   = 1'b0;
    cand    = '0;
    unique case (state)
      IDLE: begin
        if (|Req) begin
          grant = 1'b1;
          cand  = Req;
        end
      end
      BUSY: begin
        if (!owner_req) begin
          // Release: hand over directly when someone waits, so Gate never idles.
          if (|others) begin
            grant = 1'b1;
            cand  = others;
          end else begin
            state_n = IDLE;
            gate_n  = '0;
            valid_n = 1'b0;
            id_n    = '0;
            cnt_n   = '0;
          end
        end else if (at_limit && !Lock && |others) begin
          grant = 1'b1;
          cand  = others;
          to_n  = 1'b1;
        end else if (!at_limit) begin
          cnt_n = hold_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (grant && pick_res[2]) begin
      state_n = BUSY;
      gate_n  = 4'b0001 << pick_res[1:0];
      valid_n = 1'b1;
      id_n    = pick_res[1:0];
      ptr_n   = pick_res[1:0] + 2'd1;
      cnt_n   = CNT_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      hold_cnt    <= '0;
      Gate        <= '0;
      Grant_valid <= 1'b0;
      Grant_id    <= '0;
      Timeout     <= 1'b0;
    end else begin
      state       <= state_n;
      rr_ptr      <= ptr_n;
      hold_cnt    <= cnt_n;
      Gate        <= gate_n;
      Grant_valid <= valid_n;
      Grant_id    <= id_n;
      Timeout     <= to_n;
    end
  end

endmodule

// File: tb/tb_bus_gate_arbiter.sv
// Scoreboard bench for bus_gate_arbiter: directed per-cycle stimulus pushes the
// hand-computed registered response; a monitor pops and compares every cycle.
module tb_bus_gate_arbiter;

  logic       Clk;
  logic       Reset;
  logic [3:0] Req;
  logic       Lock;
  logic [3:0] Gate;
  logic       Grant_valid;
  logic [1:0] Grant_id;
  logic       Timeout;

  typedef struct packed {
    logic [3:0] gate;
    logic [1:0] id;
    logic       to;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  bit   stim_done = 0;

  bus_gate_arbiter #(.MAX_HOLD(8)) dut (
    .Clk(Clk), .Reset(Reset), .Req(Req), .Lock(Lock),
    .Gate(Gate), .Grant_valid(Grant_valid), .Grant_id(Grant_id), .Timeout(Timeout)
  );

  initial Clk = 0;
  always #5 Clk = ~Clk;

  // Apply inputs for one cycle and queue the outputs expected after the next edge.
  task automatic step(input logic rst, input logic [3:0] r, input logic lk,
                      input logic [3:0] eg, input logic [1:0] eid, input logic eto);
    exp_t e;
    @(posedge Clk);
    #2;
    Reset = rst;
    Req   = r;
    Lock  = lk;
    e.gate = eg;
    e.id   = eid;
    e.to   = eto;
    sb.push_back(e);
  endtask

  always @(posedge Clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (Gate !== e.gate || Grant_valid !== (|e.gate) || Grant_id !== e.id || Timeout !== e.to) begin
        failures++;
        $display("FAIL outputs t=%0t: Gate=%b valid=%b id=%0d to=%b, required Gate=%b valid=%b id=%0d to=%b",
                 $time, Gate, Grant_valid, Grant_id, Timeout, e.gate, |e.gate, e.id, e.to);
      end
      checks++;
      if (!$onehot0(Gate)) begin
        failures++;
        $display("FAIL onehot t=%0t: Gate=%b, required at most one bit set", $time, Gate);
      end
    end
  end

  initial begin
    Reset = 1;
    Req   = 4'b1111;
    Lock  = 0;
    // Reset held with all requests: bus stays idle.
    step(1, 4'b1111, 0, 4'b0000, 0, 0);
    step(1, 4'b1111, 0, 4'b0000, 0, 0);
    // Release with all requesting: round-robin sweep, 8 cycles each, Timeout at handovers.
    for (int o = 0; o < 5; o++) begin
      step(0, 4'b1111, 0, 4'b0001 << (o % 4), 2'(o % 4), o > 0);
      for (int k = 0; k < 7; k++)
        step(0, 4'b1111, 0, 4'b0001 << (o % 4), 2'(o % 4), 0);
    end
    // Reset mid-grant.
    step(1, 4'b1111, 0, 4'b0000, 0, 0);
    // ALU alone for 3 cycles, then idle.
    for (int k = 0; k < 3; k++) step(0, 4'b0010, 0, 4'b0010, 1, 0);
    step(0, 4'b0000, 0, 4'b0000, 0, 0);
    step(0, 4'b0000, 0, 4'b0000, 0, 0);
    // MDR owner releases while PC waits: direct one-hot to one-hot handover.
    step(0, 4'b0001, 0, 4'b0001, 0, 0);
    step(0, 4'b0001, 0, 4'b0001, 0, 0);
    step(0, 4'b0100, 0, 4'b0100, 2, 0);
    step(0, 4'b0000, 0, 4'b0000, 0, 0);
    // Lock holds MDR past the limit; dropping Lock preempts at the next edge.
    step(0, 4'b0001, 0, 4'b0001, 0, 0);
    for (int k = 0; k < 20; k++) step(0, 4'b0011, 1, 4'b0001, 0, 0);
    step(0, 4'b0011, 0, 4'b0010, 1, 1);
    step(0, 4'b0010, 0, 4'b0010, 1, 0);
    // Reset while ALU owns; first grant afterwards is MDR.
    step(1, 4'b1111, 0, 4'b0000, 0, 0);
    step(0, 4'b1111, 0, 4'b0001, 0, 0);
    for (int k = 0; k < 7; k++) step(0, 4'b1111, 0, 4'b0001, 0, 0);
    // Owner drops exactly at the hold limit: plain release, no Timeout.
    step(0, 4'b1110, 0, 4'b0010, 1, 0);
    // Owner alone beyond the limit keeps the bus.
    for (int k = 0; k < 10; k++) step(0, 4'b0010, 0, 4'b0010, 1, 0);
    step(0, 4'b0000, 0, 4'b0000, 0, 0);
    repeat (3) @(posedge Clk);
    #3;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d entries left, required 0", sb.size());
    end
    stim_done = 1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    if (!stim_done) begin
      $display("FAIL watchdog: run exceeded time limit, required completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1);
    end
  end

endmodule
